// File: rtl/check_tally_pkg.sv
// Shared types and helpers for the check_tally result accumulator.
// State encoding, total-count width and a saturating increment.
package check_tally_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tally_state_e;

    localparam int TOTAL_W = 16;

    // Holds at the all-ones value of the low w bits (w <= 32).
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] max;
        max = 32'hFFFF_FFFF >> (32 - w);
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/check_tally_sat_counter.sv
// Saturating up-counter with synchronous reset and run-start clear.
// Used for the pass and fail tallies of check_tally.
module sat_counter
    import check_tally_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_at_max
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= W'(sat_inc(32'(r_cnt), W));
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_max = (r_cnt == '1);

endmodule

// File: rtl/check_tally.sv
// Pass/fail result accumulator with run FSM and sticky status flags.
// Optional fail-streak abort is built when CHECK_TALLY_STREAK_EN is defined.
module check_tally
    import check_tally_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int EXPECTED     = 13,
    parameter int STREAK_LIMIT = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_res_valid,
    input  logic               i_res_pass,
    output logic               o_res_ready,
    output logic [CNT_W-1:0]   o_pass_cnt,
    output logic [CNT_W-1:0]   o_fail_cnt,
    output logic [TOTAL_W-1:0] o_total_cnt,
    output logic               o_sat,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_abort
);

    localparam logic [TOTAL_W-1:0] EXP_V = TOTAL_W'(EXPECTED);

    tally_state_e       r_state;
    logic               r_busy;
    logic               r_done;
    logic [TOTAL_W-1:0] r_total;

    logic w_acc;
    logic w_clr;
    logic w_last;
    logic w_abort_hit;
    logic w_pass_max;
    logic w_fail_max;

    assign w_acc  = i_res_valid & r_busy;
    assign w_clr  = i_start & ~r_busy;
    assign w_last = w_acc & ((r_total + 1'b1) == EXP_V);

    sat_counter #(.W(CNT_W)) u_pass (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_clr),
        .i_inc    (w_acc & i_res_pass),
        .o_cnt    (o_pass_cnt),
        .o_at_max (w_pass_max)
    );

    sat_counter #(.W(CNT_W)) u_fail (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_clr),
        .i_inc    (w_acc & ~i_res_pass),
        .o_cnt    (o_fail_cnt),
        .o_at_max (w_fail_max)
    );

`ifdef CHECK_TALLY_STREAK_EN
    localparam int SW = $clog2(STREAK_LIMIT + 1);
    localparam logic [SW-1:0] LIM_M1 = SW'(STREAK_LIMIT - 1);

    logic [SW-1:0] r_streak;
    logic          r_abort;

    assign w_abort_hit = w_acc & ~i_res_pass & (r_streak == LIM_M1);

    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr) begin
            r_streak <= '0;
            r_abort  <= 1'b0;
        end else if (w_acc) begin
            r_streak <= i_res_pass ? '0 : r_streak + 1'b1;
            if (w_abort_hit) begin
                r_abort <= 1'b1;
            end
        end
    end

    assign o_abort = r_abort;
`else
    logic w_unused_lim;

    assign w_abort_hit  = 1'b0;
    assign o_abort      = 1'b0;
    assign w_unused_lim = ^STREAK_LIMIT;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_total <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_total <= '0;
                    end
                end
                RUN: begin
                    if (w_acc) begin
                        r_total <= r_total + 1'b1;
                        if (w_last || w_abort_hit) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Counts only rise within a run, so "hit max this run" equals "at max now".
    assign o_sat       = w_pass_max | w_fail_max;
    assign o_res_ready = r_busy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_total_cnt = r_total;

endmodule

// File: doc/check_tally.md
# check_tally

Result-accumulation stage that sits directly upstream of the end-of-simulation report. It accepts a stream of per-check pass/fail results over a valid/ready handshake and keeps saturating pass, fail and total counts. It raises `done` once a programmed number of results has been consumed. The report logic samples its counters and status flags after `done`.

## Interface
- `CNT_W`, 4: width of `pass_cnt` and `fail_cnt`; both saturate at 2^CNT_W-1.
- `EXPECTED`, 13: number of results per run; legal range 1 to 2^16-1.
- `STREAK_LIMIT`, 3: consecutive-fail count that triggers abort; only used when `CHECK_TALLY_STREAK_EN` is defined; legal range ≥1.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; clears counters and begins a run.
- `res_valid`  in  1  result present.
- `res_pass`  in  1  result value: 1 = pass, 0 = fail; qualified by `res_valid`.
- `res_ready`  out  1  block can accept a result.
- `pass_cnt`  out  CNT_W  passes accepted this run.
- `fail_cnt`  out  CNT_W  fails accepted this run.
- `total_cnt`  out  16  results accepted this run; never saturates (bounded by EXPECTED).
- `sat`  out  1  sticky; either count hit its maximum this run.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `abort`  out  1  sticky; run ended on the fail streak.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - `start` → RUN; clears all counters, `sat`, `abort` and the streak counter.
  - Results are not accepted in this state.
- RUN:
  - Accept: `res_valid & res_ready`.
  - Pass accepted: `pass_cnt` += 1, held at max when saturated; streak cleared.
  - Fail accepted: `fail_cnt` += 1, held at max when saturated; streak += 1.
  - Every accept: `total_cnt` += 1.
  - `sat` sets on the accept that moves a count to its max. An accept made while a count is already at max leaves that count unchanged.
  - The accept that makes `total_cnt` equal EXPECTED → DONE.
  - `start` is ignored in RUN.
- DONE:
  - Counters and flags hold.
  - `start` → RUN with clears as in IDLE.
  - Results are not accepted in this state.
- `rst` mid-run: state goes to IDLE, all outputs go to 0, and any result in flight is discarded.

## Timing
- Reset values: `res_ready`, `busy`, `done`, `sat` and `abort` are 0; `pass_cnt`, `fail_cnt` and `total_cnt` are 0.
- `res_ready` = (state == RUN). It is decoded from state only, with no combinational path from `res_valid`.
- The upstream source may hold `res_valid` across cycles; each cycle in which `res_valid & res_ready` is high counts as exactly one result.
- Counters update on the clock edge of the accept and are visible the next cycle.
- `done` and `busy` change on the same edge as the final counter update. `res_ready` drops on that same edge, so no result is accepted after the EXPECTED-th.
- `start` in IDLE or DONE: `busy` = 1 and `res_ready` = 1 in the next cycle. The earliest accept is in that cycle.
- Simultaneous `rst` and `start`: `rst` wins.

## Configuration
- Macro: `CHECK_TALLY_STREAK_EN`.
- Defined:
  - A fail accept that makes the streak equal STREAK_LIMIT sets `abort` and moves the FSM to DONE on that edge, even when `total_cnt` < EXPECTED.
  - The streak counter has width $clog2(STREAK_LIMIT+1) and is cleared by any pass.
- Not defined:
  - No streak logic is built.
  - `abort` is tied to 0.
  - A run ends only when EXPECTED results have been accepted.

## Structure
- Package `check_tally_pkg`:
  - FSM state enum `tally_state_e` (IDLE, RUN, DONE).
  - `TOTAL_W` = 16.
  - A saturating-increment function parameterised by width.
- Sub-module `sat_counter`:
  - One instance for `pass_cnt`, one for `fail_cnt`.
  - Ports: `clk`, `rst`, `clr`, `inc`, `cnt`, `at_max`.
- The top level holds the FSM, `total_cnt`, the streak logic and the sticky flags.

## Test plan
- Alternating results, default parameters: start, then 13 accepts with `res_pass` = i%2 for i = 0..12 → `pass_cnt` = 6, `fail_cnt` = 7, `total_cnt` = 13; `done` rises the cycle after the 13th accept; `sat` = 0.
- Saturation, CNT_W = 4, EXPECTED = 20: 20 passes → `pass_cnt` = 15, `sat` = 1, `total_cnt` = 20, `done` = 1.
- Streak abort, macro defined: start, then results pass, fail, fail, fail → `abort` = 1, `done` = 1, `total_cnt` = 4, `fail_cnt` = 3. Same sequence with the macro undefined → `abort` = 0, `busy` = 1.
- Handshake gating: `res_valid` held high in IDLE and DONE for 5 cycles → counts unchanged. Gaps in `res_valid` during RUN → only cycles with valid and ready count.
- Reset mid-run: `rst` pulse after 5 accepts → the next cycle has all outputs 0 and state IDLE. Then `start` plus 13 results → normal completion.
- Restart from DONE: `start` pulse in DONE → next cycle has counters 0, `done` = 0, `busy` = 1. A `start` pulse during RUN → no effect on the counts.
